// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction fetch unit placed directly in front of the RAM instruction port.
// Each cycle it may issue one fetch. The RAM returns the word combinationally
// in the same cycle, and that word is captured into a small prefetch FIFO.
// The FIFO head is presented to decode with a valid/ready handshake.
// A flush redirects the fetch PC and discards everything that is buffered.
// A halt stops new fetches while the FIFO keeps draining.
//
// Parameters:
//   RESET_PC      first fetch address after reset (word aligned)
//   DEPTH         prefetch FIFO entries (power of two, 2..8)
//
// Ports:
//   clk_i         clock
//   n_rst_i       asynchronous active-low reset
//   fetch_ce_o    RAM instruction port chip enable
//   fetch_addr_o  RAM instruction fetch address (always word aligned)
//   fetch_data_i  RAM instruction word, valid in the cycle fetch_ce_o is high
//   inst_valid_o  FIFO head holds a valid instruction
//   inst_ready_i  decode accepts the head this cycle
//   inst_o        head instruction word (0 when empty)
//   inst_addr_o   fetch address of the head instruction (0 when empty)
//   flush_i       redirect: drop buffered and in-flight fetches
//   flush_pc_i    redirect target; bits [1:0] are ignored
//   halt_i        stop issuing new fetches; buffered entries still drain
// ---------------------------------------------------------------------------
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    output logic        fetch_ce_o,
    output logic [31:0] fetch_addr_o,
    input  logic [31:0] fetch_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        halt_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [31:0]   RESET_PCA = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc;
    logic          running;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic pop;
    logic push;

    assign pop  = (count != '0) & inst_ready_i;

    // A full FIFO may still fetch when its head leaves in the same cycle,
    // which keeps back-to-back throughput at one instruction per cycle.
    assign push = running & ~halt_i & ~flush_i & ((count < DEPTH_C) | pop);

    assign fetch_ce_o   = push;
    assign fetch_addr_o = fetch_pc;

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? data_mem[rd_ptr] : 32'h0;
    assign inst_addr_o  = inst_valid_o ? addr_mem[rd_ptr] : 32'h0;

    // Control state. Flush wins over push/pop: the FIFO is simply cleared,
    // and the PC jumps to the aligned redirect target.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            fetch_pc <= RESET_PCA;
            running  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            running <= 1'b1;
            if (flush_i) begin
                fetch_pc <= {flush_pc_i[31:2], 2'b00};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Entry storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr] <= fetch_pc;
            data_mem[wr_ptr] <= fetch_data_i;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Self-checking bench for ifu_prefetch. A combinational RAM model feeds
// fetch_data_i. A queue-based reference model tracks the program counter
// and the buffered instructions. Inputs change 1 ns after each rising edge.
// Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        n_rst;
    logic        fetch_ce;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_pop;
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_iaddr;

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .n_rst_i     (n_rst),
        .fetch_ce_o  (fetch_ce),
        .fetch_addr_o(fetch_addr),
        .fetch_data_i(fetch_data),
        .inst_valid_o(inst_valid),
        .inst_ready_i(inst_ready),
        .inst_o      (inst),
        .inst_addr_o (inst_addr),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .halt_i      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return (a * 32'd7) ^ 32'hC3C3_0001;
        endcase
    endfunction

    assign fetch_data = ram_word(fetch_addr);

    function automatic string obs_str();
        return $sformatf("ce=%b addr=%h v=%b inst=%h ia=%h",
                         fetch_ce, fetch_addr, inst_valid, inst, inst_addr);
    endfunction

    function automatic string exp_str();
        return $sformatf("ce=%b addr=%h v=%b inst=%h ia=%h",
                         exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr);
    endfunction

    task automatic set_inputs(input logic rdy, input logic fl,
                              input logic [31:0] fpc, input logic hl);
        inst_ready = rdy;
        flush      = fl;
        flush_pc   = fpc;
        halt       = hl;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = {RESET_PC[31:2], 2'b00};
        m_run = 1'b0;
    endtask

    // Expected outputs for the current cycle, from model state and inputs.
    task automatic model_expect();
        exp_valid = (mq.size() != 0);
        exp_inst  = exp_valid ? mq[0][31:0]  : 32'h0;
        exp_iaddr = exp_valid ? mq[0][63:32] : 32'h0;
        m_pop     = exp_valid && inst_ready;
        exp_ce    = m_run && !halt && !flush && ((mq.size() < DEPTH) || m_pop);
        exp_addr  = m_pc;
    endtask

    task automatic model_advance();
        if (flush) begin
            mq.delete();
            m_pc = {flush_pc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (exp_ce) begin
                mq.push_back({m_pc, ram_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_run = 1'b1;
    endtask

    task automatic do_reset();
        set_inputs(1'b0, 1'b0, 32'h0, 1'b0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b0, 32'h0, 1'b0);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
            {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %s, expected ce=0 addr=%h v=0 inst=0 ia=0",
                     obs_str(), RESET_PC);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
    endtask

    // Streaming with decode always ready: addresses 0,4,8,C then 11..44.
    task automatic test_stream();
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        int na = 0;
        int nd = 0;
        exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int c = 0; c < 7; c++) begin
            set_inputs(1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL stream_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c == 0) begin
                checks++;
                if (fetch_ce !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL first_cycle_no_fetch: got ce=%b, expected 0", fetch_ce);
                end
            end
            if (fetch_ce === 1'b1 && na < 4) begin
                checks++;
                if (fetch_addr !== exp_a[na]) begin
                    errors++;
                    $display("[TB] FAIL stream_addr %0d: got %h, expected %h", na, fetch_addr, exp_a[na]);
                end
                na++;
            end
            if (inst_valid === 1'b1 && nd < 4) begin
                checks++;
                if ({inst, inst_addr} !== {exp_d[nd], exp_a[nd]}) begin
                    errors++;
                    $display("[TB] FAIL stream_inst %0d: got %h@%h, expected %h@%h",
                             nd, inst, inst_addr, exp_d[nd], exp_a[nd]);
                end
                nd++;
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // Decode stalled: exactly DEPTH fetches, head stable, then pop+fetch together.
    task automatic test_stall();
        int fetches = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_inputs(c == 5, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL stall_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c < 5 && fetch_ce === 1'b1) fetches++;
            if (c == 4) begin
                checks++;
                if (fetches != DEPTH) begin
                    errors++;
                    $display("[TB] FAIL stall_fetch_count: got %0d, expected %0d", fetches, DEPTH);
                end
                checks++;
                if ({inst_valid, inst, inst_addr} !== {1'b1, 32'h11, 32'h0}) begin
                    errors++;
                    $display("[TB] FAIL stall_head: got v=%b %h@%h, expected v=1 00000011@00000000",
                             inst_valid, inst, inst_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if ({fetch_ce, fetch_addr} !== {1'b1, 32'h8}) begin
                    errors++;
                    $display("[TB] FAIL full_pop_fetch: got ce=%b addr=%h, expected ce=1 addr=00000008",
                             fetch_ce, fetch_addr);
                end
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // Flush with a full FIFO to an unaligned target.
    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            set_inputs(1'b0, c == 0, 32'h0000_0103, 1'b0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL flush_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c == 1) begin
                checks++;
                if ({inst_valid, fetch_ce, fetch_addr} !== {1'b0, 1'b1, 32'h100}) begin
                    errors++;
                    $display("[TB] FAIL flush_redirect: got v=%b ce=%b addr=%h, expected v=0 ce=1 addr=00000100",
                             inst_valid, fetch_ce, fetch_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if ({inst_valid, inst_addr} !== {1'b1, 32'h100}) begin
                    errors++;
                    $display("[TB] FAIL flush_first_inst: got v=%b ia=%h, expected v=1 ia=00000100",
                             inst_valid, inst_addr);
                end
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // Redirect to 0, stream up to PC 0x10, halt for 3 cycles, then resume.
    task automatic test_halt();
        for (int c = 0; c < 10; c++) begin
            set_inputs(1'b1, c == 0, 32'h0, (c >= 5 && c <= 7));
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL halt_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if ({fetch_ce, fetch_addr} !== {1'b0, 32'h10}) begin
                    errors++;
                    $display("[TB] FAIL halt_blocks cyc %0d: got ce=%b addr=%h, expected ce=0 addr=00000010",
                             c, fetch_ce, fetch_addr);
                end
            end
            if (c == 8) begin
                checks++;
                if ({inst_valid, fetch_ce, fetch_addr} !== {1'b0, 1'b1, 32'h10}) begin
                    errors++;
                    $display("[TB] FAIL halt_resume: got v=%b ce=%b addr=%h, expected v=0 ce=1 addr=00000010",
                             inst_valid, fetch_ce, fetch_addr);
                end
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // PC wraps from the top of the address space back to zero.
    task automatic test_wrap();
        for (int c = 0; c < 4; c++) begin
            set_inputs(1'b1, c == 0, 32'hFFFF_FFFF, 1'b0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL wrap_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c == 1 || c == 2) begin
                checks++;
                if ({fetch_ce, fetch_addr} !== {1'b1, (c == 1) ? 32'hFFFF_FFFC : 32'h0}) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr cyc %0d: got ce=%b addr=%h, expected ce=1 addr=%h",
                             c, fetch_ce, fetch_addr, (c == 1) ? 32'hFFFF_FFFC : 32'h0);
                end
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // Random ready/halt/flush traffic against the reference model.
    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       $urandom, $urandom_range(0, 7) == 0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL random_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted between edges drops outputs at once; restart at RESET_PC.
    task automatic test_async_reset();
        set_inputs(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        model_expect();
        model_advance();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            set_inputs(1'b1, 1'b0, 32'h0, 1'b0);
            model_expect();
            model_advance();
            @(posedge clk);
            #1;
        end
        #2;
        checks++;
        if ({inst_valid, fetch_ce} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pre_reset_active: got v=%b ce=%b, expected v=1 ce=1", inst_valid, fetch_ce);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({inst_valid, fetch_ce, inst, fetch_addr} !== {1'b0, 1'b0, 32'h0, RESET_PC}) begin
            errors++;
            $display("[TB] FAIL async_reset_drop: got v=%b ce=%b inst=%h addr=%h, expected v=0 ce=0 inst=0 addr=%h",
                     inst_valid, fetch_ce, inst, fetch_addr, RESET_PC);
        end
        model_reset();
        @(posedge clk);
        #3;
        n_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_inputs(1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            model_expect();
            checks++;
            if ({fetch_ce, fetch_addr, inst_valid, inst, inst_addr} !==
                {exp_ce, exp_addr, exp_valid, exp_inst, exp_iaddr}) begin
                errors++;
                $display("[TB] FAIL restart_model cyc %0d: got %s, expected %s", c, obs_str(), exp_str());
            end
            if (c == 1) begin
                checks++;
                if ({fetch_ce, fetch_addr} !== {1'b1, RESET_PC}) begin
                    errors++;
                    $display("[TB] FAIL restart_addr: got ce=%b addr=%h, expected ce=1 addr=%h",
                             fetch_ce, fetch_addr, RESET_PC);
                end
            end
            model_advance();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_rst = 1'b0;
        set_inputs(1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_halt();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch unit sitting directly upstream of the dual-port RAM instruction port.
- Drives the RAM fetch chip-enable and address, captures the same-cycle combinational instruction word, and buffers it in a small FIFO.
- Presents instructions to the decode stage with a valid/ready handshake.
- Supports pipeline flush/redirect and fetch halt.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release; low 2 bits must be 0.
- DEPTH, 2, prefetch FIFO entries; power of two, 2..8.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  asynchronous active-low reset
- fetch_ce_o  out  1  instruction port chip enable to RAM
- fetch_addr_o  out  32  instruction fetch address to RAM, always word-aligned
- fetch_data_i  in  32  instruction word from RAM, valid in the same cycle as fetch_ce_o
- inst_valid_o  out  1  FIFO head holds a valid instruction
- inst_ready_i  in  1  decode accepts the head this cycle
- inst_o  out  32  head instruction word
- inst_addr_o  out  32  address the head instruction was fetched from
- flush_i  in  1  redirect request: discard buffered and in-flight fetches
- flush_pc_i  in  32  redirect target; bits [1:0] are ignored and forced to 0
- halt_i  in  1  stop issuing new fetches; buffered entries still drain

Behaviour:
- Reset, asynchronous, while n_rst_i=0:
  - fetch_pc=RESET_PC, FIFO empty (count=0, rd/wr pointers 0), running=0.
  - Outputs: inst_valid_o=0, fetch_ce_o=0, inst_o=0, inst_addr_o=0.
  - fetch_addr_o=RESET_PC.
- running:
  - Register set to 1 on the first clock edge after reset deasserts.
  - No fetch is issued in that first cycle.
  - Reset mid-operation drops all state immediately.
- pop = inst_valid_o & inst_ready_i.
- Fetch enable (combinational): fetch_ce_o = running & ~halt_i & ~flush_i & (count<DEPTH | pop).
  - A full FIFO fetches in the same cycle it is popped.
- fetch_addr_o = fetch_pc, combinational from the register.
- Push: in any cycle with fetch_ce_o=1, {fetch_pc, fetch_data_i} is written at wr_ptr and fetch_pc <= fetch_pc+4.
  - Addition is 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
- Pop: head entry is removed and rd_ptr advances.
- Count update:
  - Simultaneous push and pop: count unchanged.
  - Push only: +1.
  - Pop only: -1.
- Head outputs:
  - inst_valid_o = (count!=0).
  - inst_o and inst_addr_o show the head entry while valid; they are 0 when empty.
  - Head outputs are held stable while valid and not accepted.
- Fill latency: a fetch issued in cycle N appears at the head in cycle N+1 if the FIFO was empty. There is no combinational RAM-to-decode path.
- Flush (flush_i=1 at a clock edge) has priority over everything:
  - FIFO is emptied (count=0, pointers 0).
  - fetch_pc <= {flush_pc_i[31:2],2'b00}.
  - No push that cycle (fetch_ce_o is already 0).
  - A pop in the same cycle is still reported to decode via the handshake; ownership of that instruction is the decoder's concern. The FIFO itself is simply cleared.
  - First fetch from the new target occurs in the cycle after flush; that instruction is valid the cycle after that.
- Halt:
  - halt_i=1 blocks new fetches only; fetch_pc is held.
  - Pops continue.
  - Deasserting halt_i resumes fetching at the held fetch_pc.
  - flush_i during halt still redirects fetch_pc.
- Boundaries:
  - Overflow is impossible: push is gated by the full condition.
  - Pop when empty is impossible: inst_valid_o=0.
  - inst_ready_i is ignored when the FIFO is empty.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset release, RAM words 0..3 = 32'h11,22,33,44, inst_ready_i=1 -> cycle 0 after release: no fetch.
  - Then fetch_addr_o = 0,4,8,C on consecutive cycles.
  - inst_o = 11,22,33,44 one cycle later, with inst_addr_o = 0,4,8,C.
- inst_ready_i=0 held 5 cycles -> exactly DEPTH=2 fetches (addresses 0,4), then fetch_ce_o=0.
  - Head stays 32'h11 at addr 0.
  - On ready=1, fetch of 8 is issued in the same cycle as the pop of entry 0.
- flush_i=1 with flush_pc_i=32'h0000_0103, FIFO full -> next cycle inst_valid_o=0 and fetch_addr_o=32'h100.
  - The following cycle: inst_addr_o=32'h100.
- halt_i=1 for 3 cycles mid-stream at fetch_pc=32'h10 -> no fetch_ce_o and the FIFO drains.
  - After release, the fetch resumes at 32'h10 with no skipped or duplicated address.
- fetch_pc forced via flush to 32'hFFFF_FFFC -> next fetch addresses are FFFF_FFFC then 0000_0000.
- n_rst_i asserted asynchronously mid-stream (between edges) -> inst_valid_o and fetch_ce_o drop to 0 immediately.
  - After release, fetching restarts at RESET_PC.
